spike_out_collector: RTL and testbench
======================================

Name: spike_out_collector

Overview:
- Sits directly downstream of the neuron columns. It consumes the per-column one-cycle output spike pulses and serialises them into a single timestamped event stream for readout.
- Each spike is latched per column, stamped with the cycle it fired, arbitrated round-robin, and buffered in a FIFO.
- The FIFO drains over a valid/ready handshake. Spikes that cannot be latched are counted, never silently lost.

Parameters:
- NUM_COLS, 1, number of neuron columns (≥1).
- TS_WIDTH, 16, timestamp counter width (≥2).
- FIFO_DEPTH, 8, event FIFO entries (power of 2, ≥2).
- COL_W (localparam), max(1, clog2(NUM_COLS)), column address width.

Ports:
- clk, input, 1, main clock (driven from sys_if.main_clk).
- reset, input, 1, synchronous active-high reset.
- spike_in, input, NUM_COLS, one-cycle spike pulse per neuron column.
- event_valid, output, 1, FIFO head holds a valid event.
- event_ready, input, 1, consumer accepts the head event.
- event_col, output, COL_W, column index of the head event.
- event_time, output, TS_WIDTH, timestamp of the head event.
- pending, output, NUM_COLS, per-column latched-but-ungranted flags.
- fifo_level, output, clog2(FIFO_DEPTH)+1, current FIFO occupancy.
- dropped_count, output, 16, saturating count of dropped spikes.

Behaviour:
- One clock domain; reset is synchronous and active-high. All registers are updated on the rising edge of clk.
- Reset values: timestamp 0, pending all 0, per-column stored timestamps 0, RR pointer 0, FIFO empty, event_valid 0, event_col 0, event_time 0, fifo_level 0, dropped_count 0.
- Reset asserted mid-operation discards all pending and buffered events. It does not increment dropped_count.
- Timestamp counter: free-running, +1 per cycle, wraps from 2^TS_WIDTH−1 to 0 with no flag.
- Capture: if spike_in[j]=1 at an edge, pending[j] is set and ts[j] is loaded with the counter value of that cycle (pre-increment).
- Conflict:
  - If spike_in[j]=1 while pending[j]=1 and column j is not granted this cycle, the new spike is dropped and dropped_count increments, saturating at 0xFFFF.
  - If column j is granted in the same cycle, the new spike is latched with its own timestamp and is not counted as a drop.
  - Several columns dropping in one cycle add their combined count, still saturating.
- Arbitration: combinational round-robin over pending, searching upward from the RR pointer and wrapping.
  - A grant is issued only when fifo_level < FIFO_DEPTH. A pop in the same cycle does not unblock a full FIFO.
  - On a grant: write {col, ts[col]} into the FIFO, clear pending[col] (unless re-set as above), set pointer = col+1 mod NUM_COLS.
  - Exactly one grant per cycle at most.
- FIFO: show-ahead. event_valid = not empty, and event_col/event_time reflect the head entry.
  - A pop happens on an edge where event_valid and event_ready are both 1.
  - A simultaneous push and pop leaves level unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
  - When empty, event_col/event_time hold their last values and are don't-care.
- Latency: spike at cycle t → pending at t+1 → with an uncontended, non-full FIFO, event_valid=1 at t+2.
- Backpressure: with the FIFO full, pending flags hold indefinitely. Further spikes on pending columns are counted as drops.
- NUM_COLS=1: arbiter degenerates, pointer stays 0, event_col stays 0.

Decomposition:
- Shared package spike_evt_pkg holds:
  - typedef spike_event_t (packed struct: col, time), parameterised via package constants or module-local typedef.
  - Function col_width(n) returning max(1, clog2(n)).
  - DROP_CNT_W = 16.
- Sub-module spike_event_fifo, a generic synchronous show-ahead FIFO:
  - Parameters: width, depth.
  - Ports: push, pop, din, dout, empty, full, level.
  - The arbiter, pending/timestamp latches and drop counter stay in the top module.

Test Plan:
- Single spike: NUM_COLS=4, spike_in=4'b0100 at timestamp 10, ready=1 → event_valid at t+2 with col=2, time=10, then level returns to 0.
- Simultaneous spikes: spike_in=4'b1111 in one cycle with the pointer at 0 → events emerge in col order 0,1,2,3, all with the same time, on consecutive cycles.
- Round-robin fairness: hold columns 1 and 3 firing every cycle → grants alternate 1,3,1,3. Drops count 1 per column per non-granted cycle.
- Full FIFO: DEPTH=8, ready=0, 12 distinct spikes → level=8, event_valid=1, 4 pending bits held, dropped_count=0. Raise ready → all 12 delivered in order.
- Drop saturation: pending[0] held with the FIFO full, spike_in[0]=1 for 70000 cycles → dropped_count=0xFFFF and does not wrap.
- Reset mid-stream and wrap: reset with level=5 → next cycle level=0, valid=0, pending=0, timestamp=0. TS_WIDTH=4 with a spike at count 15 and the next at count 0 → event times 15 then 0.

Source files
------------

// File: rtl/spike_evt_pkg.sv
// Shared constants and helpers for the spike readout path.
package spike_evt_pkg;

    localparam int DROP_CNT_W = 16;

    // Column address width, never narrower than one bit.
    function automatic int col_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/spike_event_fifo.sv
// Generic synchronous show-ahead FIFO: dout is the head entry whenever not empty.
module spike_event_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                   clk_i,
    input  logic                   reset_i,
    input  logic                   push_i,
    input  logic                   pop_i,
    input  logic [WIDTH-1:0]       din_i,
    output logic [WIDTH-1:0]       dout_o,
    output logic                   empty_o,
    output logic                   full_o,
    output logic [$clog2(DEPTH):0] level_o
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_q, wr_d;
    logic [AW-1:0]    rd_q, rd_d;
    logic [AW:0]      cnt_q, cnt_d;
    logic             do_push, do_pop;

    assign empty_o = (cnt_q == '0);
    assign full_o  = (cnt_q == (AW+1)'(DEPTH));
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign dout_o  = mem_q[rd_q];
    assign level_o = cnt_q;

    always_comb begin
        wr_d  = wr_q;
        rd_d  = rd_q;
        cnt_d = cnt_q;
        if (do_push) wr_d = wr_q + AW'(1);
        if (do_pop)  rd_d = rd_q + AW'(1);
        if (do_push && !do_pop)      cnt_d = cnt_q + (AW+1)'(1);
        else if (do_pop && !do_push) cnt_d = cnt_q - (AW+1)'(1);
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
            if (do_push) mem_q[wr_q] <= din_i;
        end
    end

endmodule

// File: rtl/spike_out_collector.sv
// Latches per-column spike pulses with their fire time, arbitrates round-robin
// into an event FIFO and counts spikes that arrive while their column is busy.
module spike_out_collector
    import spike_evt_pkg::*;
#(
    parameter  int NUM_COLS   = 1,
    parameter  int TS_WIDTH   = 16,
    parameter  int FIFO_DEPTH = 8,
    localparam int COL_W      = col_width(NUM_COLS),
    localparam int LVL_W      = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic [NUM_COLS-1:0]   spike_in_i,
    output logic                  event_valid_o,
    input  logic                  event_ready_i,
    output logic [COL_W-1:0]      event_col_o,
    output logic [TS_WIDTH-1:0]   event_time_o,
    output logic [NUM_COLS-1:0]   pending_o,
    output logic [LVL_W-1:0]      fifo_level_o,
    output logic [DROP_CNT_W-1:0] dropped_count_o
);

    typedef struct packed {
        logic [COL_W-1:0]    col;
        logic [TS_WIDTH-1:0] ts;
    } spike_event_t;

    logic [TS_WIDTH-1:0]                ts_q, ts_d;
    logic [NUM_COLS-1:0]                pend_q, pend_d;
    logic [NUM_COLS-1:0][TS_WIDTH-1:0]  cts_q, cts_d;
    logic [COL_W-1:0]                   ptr_q, ptr_d;
    logic [DROP_CNT_W-1:0]              drop_q, drop_d;

    logic                gnt_vld;
    logic [COL_W-1:0]    gnt_col;
    logic [TS_WIDTH-1:0] gnt_ts;
    logic [NUM_COLS-1:0] gnt_oh;
    logic [NUM_COLS-1:0] drop_vec;
    logic [DROP_CNT_W:0] ndrop, drop_sum;

    logic         fifo_full, fifo_empty;
    spike_event_t push_evt, head_evt;

    assign ts_d = ts_q + TS_WIDTH'(1);

    // Search upward from the pointer first, then wrap from column 0.
    always_comb begin
        gnt_vld = 1'b0;
        gnt_col = '0;
        gnt_ts  = '0;
        gnt_oh  = '0;
        if (!fifo_full) begin
            for (int j = 0; j < NUM_COLS; j++) begin
                if (!gnt_vld && pend_q[j] && (j >= int'(ptr_q))) begin
                    gnt_vld   = 1'b1;
                    gnt_col   = COL_W'(j);
                    gnt_ts    = cts_q[j];
                    gnt_oh[j] = 1'b1;
                end
            end
            for (int j = 0; j < NUM_COLS; j++) begin
                if (!gnt_vld && pend_q[j]) begin
                    gnt_vld   = 1'b1;
                    gnt_col   = COL_W'(j);
                    gnt_ts    = cts_q[j];
                    gnt_oh[j] = 1'b1;
                end
            end
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (gnt_vld) begin
            if (int'(gnt_col) >= NUM_COLS - 1) ptr_d = '0;
            else                               ptr_d = gnt_col + COL_W'(1);
        end
    end

    // A granted column frees its latch this cycle, so a coincident spike is kept.
    always_comb begin
        pend_d   = pend_q;
        cts_d    = cts_q;
        drop_vec = '0;
        for (int j = 0; j < NUM_COLS; j++) begin
            if (gnt_oh[j]) pend_d[j] = 1'b0;
            if (spike_in_i[j]) begin
                if (pend_q[j] && !gnt_oh[j]) begin
                    drop_vec[j] = 1'b1;
                end else begin
                    pend_d[j] = 1'b1;
                    cts_d[j]  = ts_q;
                end
            end
        end
    end

    always_comb begin
        ndrop = '0;
        for (int j = 0; j < NUM_COLS; j++) begin
            if (drop_vec[j]) ndrop = ndrop + (DROP_CNT_W+1)'(1);
        end
        drop_sum = {1'b0, drop_q} + ndrop;
        drop_d   = drop_sum[DROP_CNT_W] ? '1 : drop_sum[DROP_CNT_W-1:0];
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            ts_q   <= '0;
            pend_q <= '0;
            cts_q  <= '0;
            ptr_q  <= '0;
            drop_q <= '0;
        end else begin
            ts_q   <= ts_d;
            pend_q <= pend_d;
            cts_q  <= cts_d;
            ptr_q  <= ptr_d;
            drop_q <= drop_d;
        end
    end

    assign push_evt.col = gnt_col;
    assign push_evt.ts  = gnt_ts;

    spike_event_fifo #(
        .WIDTH ($bits(spike_event_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .push_i  (gnt_vld),
        .pop_i   (event_ready_i),
        .din_i   (push_evt),
        .dout_o  (head_evt),
        .empty_o (fifo_empty),
        .full_o  (fifo_full),
        .level_o (fifo_level_o)
    );

    assign event_valid_o   = !fifo_empty;
    assign event_col_o     = head_evt.col;
    assign event_time_o    = head_evt.ts;
    assign pending_o       = pend_q;
    assign dropped_count_o = drop_q;

endmodule

// File: tb/tb_spike_out_collector.sv
// Directed bench: per-cycle vector table plus hand-written corner sequences.
module tb_spike_out_collector;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Main instance: 4 columns, 16-bit time, depth 8.
    logic        rst0 = 1'b1;
    logic [3:0]  spk0 = '0;
    logic        rdy0 = 1'b0;
    logic        vld0;
    logic [1:0]  col0;
    logic [15:0] tim0;
    logic [3:0]  pnd0;
    logic [3:0]  lvl0;
    logic [15:0] drp0;

    // Second instance: single column, 4-bit time, depth 2.
    logic        rst1 = 1'b1;
    logic [0:0]  spk1 = '0;
    logic        rdy1 = 1'b0;
    logic        vld1;
    logic [0:0]  col1;
    logic [3:0]  tim1;
    logic [0:0]  pnd1;
    logic [1:0]  lvl1;
    logic [15:0] drp1;

    spike_out_collector #(.NUM_COLS(4), .TS_WIDTH(16), .FIFO_DEPTH(8)) u0 (
        .clk_i(clk), .reset_i(rst0), .spike_in_i(spk0),
        .event_valid_o(vld0), .event_ready_i(rdy0), .event_col_o(col0),
        .event_time_o(tim0), .pending_o(pnd0), .fifo_level_o(lvl0),
        .dropped_count_o(drp0)
    );

    spike_out_collector #(.NUM_COLS(1), .TS_WIDTH(4), .FIFO_DEPTH(2)) u1 (
        .clk_i(clk), .reset_i(rst1), .spike_in_i(spk1),
        .event_valid_o(vld1), .event_ready_i(rdy1), .event_col_o(col1),
        .event_time_o(tim1), .pending_o(pnd1), .fifo_level_o(lvl1),
        .dropped_count_o(drp1)
    );

    typedef struct {
        logic        rst;
        logic [3:0]  spk;
        logic        rdy;
        logic        chk;
        logic        vld;
        logic [1:0]  col;
        logic [15:0] tim;
        logic [3:0]  lvl;
        logic [3:0]  pnd;
        logic [15:0] drp;
    } vec_t;

    vec_t tv[$];
    int checks = 0;
    int errors = 0;

    task automatic add(input logic rst, input logic [3:0] spk, input logic rdy,
                       input logic chk, input logic vld, input logic [1:0] col,
                       input logic [15:0] tim, input logic [3:0] lvl,
                       input logic [3:0] pnd, input logic [15:0] drp);
        vec_t v;
        v.rst = rst; v.spk = spk; v.rdy = rdy; v.chk = chk; v.vld = vld;
        v.col = col; v.tim = tim; v.lvl = lvl; v.pnd = pnd; v.drp = drp;
        tv.push_back(v);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_u0(input string tag, input logic v, input logic [3:0] l,
                          input logic [3:0] p, input logic [15:0] d);
        chk({tag, ".valid"}, 32'(vld0), 32'(v));
        chk({tag, ".level"}, 32'(lvl0), 32'(l));
        chk({tag, ".pending"}, 32'(pnd0), 32'(p));
        chk({tag, ".dropped"}, 32'(drp0), 32'(d));
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int n;

        // Single spike on column 2 at timestamp 10
        for (int i = 0; i < 10; i++) add(0, 4'b0000, 1, 1, 0, 0, 0, 0, 4'b0000, 0);
        add(0, 4'b0100, 1, 1, 0, 0, 0,  0, 4'b0000, 0);
        add(0, 4'b0000, 1, 1, 0, 0, 0,  0, 4'b0100, 0);
        add(0, 4'b0000, 1, 1, 1, 2, 10, 1, 4'b0000, 0);
        add(0, 4'b0000, 1, 1, 0, 0, 0,  0, 4'b0000, 0);
        // All columns at once, pointer at 0
        add(1, 4'b0000, 1, 0, 0, 0, 0, 0, 4'b0000, 0);
        add(0, 4'b1111, 1, 1, 0, 0, 0, 0, 4'b0000, 0);
        add(0, 4'b0000, 1, 1, 0, 0, 0, 0, 4'b1111, 0);
        add(0, 4'b0000, 1, 1, 1, 0, 0, 1, 4'b1110, 0);
        add(0, 4'b0000, 1, 1, 1, 1, 0, 1, 4'b1100, 0);
        add(0, 4'b0000, 1, 1, 1, 2, 0, 1, 4'b1000, 0);
        add(0, 4'b0000, 1, 1, 1, 3, 0, 1, 4'b0000, 0);
        add(0, 4'b0000, 1, 1, 0, 0, 0, 0, 4'b0000, 0);
        // Columns 1 and 3 firing every cycle
        add(1, 4'b0000, 1, 0, 0, 0, 0, 0, 4'b0000, 0);
        add(0, 4'b1010, 1, 1, 0, 0, 0, 0, 4'b0000, 0);
        add(0, 4'b1010, 1, 1, 0, 0, 0, 0, 4'b1010, 0);
        add(0, 4'b1010, 1, 1, 1, 1, 0, 1, 4'b1010, 1);
        add(0, 4'b1010, 1, 1, 1, 3, 0, 1, 4'b1010, 2);
        add(0, 4'b1010, 1, 1, 1, 1, 1, 1, 4'b1010, 3);
        add(0, 4'b0000, 1, 1, 1, 3, 2, 1, 4'b1010, 4);
        add(0, 4'b0000, 1, 1, 1, 1, 3, 1, 4'b1000, 4);
        add(0, 4'b0000, 1, 1, 1, 3, 4, 1, 4'b0000, 4);
        add(0, 4'b0000, 1, 1, 0, 0, 0, 0, 4'b0000, 4);

        rst0 = 1'b1; rdy0 = 1'b1;
        cyc(); cyc();
        rst0 = 1'b0;
        for (int i = 0; i < tv.size(); i++) begin
            rst0 = tv[i].rst; spk0 = tv[i].spk; rdy0 = tv[i].rdy;
            @(negedge clk);
            if (tv[i].chk) begin
                chk($sformatf("vec%0d.valid", i), 32'(vld0), 32'(tv[i].vld));
                chk($sformatf("vec%0d.level", i), 32'(lvl0), 32'(tv[i].lvl));
                chk($sformatf("vec%0d.pending", i), 32'(pnd0), 32'(tv[i].pnd));
                chk($sformatf("vec%0d.dropped", i), 32'(drp0), 32'(tv[i].drp));
                if (tv[i].vld) begin
                    chk($sformatf("vec%0d.col", i), 32'(col0), 32'(tv[i].col));
                    chk($sformatf("vec%0d.time", i), 32'(tim0), 32'(tv[i].tim));
                end
            end
            cyc();
        end

        // Full FIFO: 12 distinct spikes with ready low, then drain
        rst0 = 1'b1; spk0 = '0; rdy0 = 1'b0;
        cyc();
        rst0 = 1'b0;
        for (int k = 0; k < 12; k++) begin
            spk0 = 4'(1 << (k % 4));
            cyc();
        end
        spk0 = '0;
        cyc();
        @(negedge clk);
        chk_u0("full", 1'b1, 4'd8, 4'b1111, 16'd0);
        chk("full.head_col", 32'(col0), 32'd0);
        chk("full.head_time", 32'(tim0), 32'd0);
        cyc();
        rdy0 = 1'b1;
        n = 0;
        for (int c = 0; c < 40 && n < 12; c++) begin
            @(negedge clk);
            if (vld0) begin
                chk($sformatf("drain%0d.col", n), 32'(col0), 32'(n % 4));
                chk($sformatf("drain%0d.time", n), 32'(tim0), 32'(n));
                n++;
            end
            cyc();
        end
        chk("drain.count", 32'(n), 32'd12);
        @(negedge clk);
        chk_u0("drained", 1'b0, 4'd0, 4'b0000, 16'd0);
        cyc();

        // Two columns hammering a full FIFO: combined and saturating drops
        rst0 = 1'b1; rdy0 = 1'b0;
        cyc();
        rst0 = 1'b0; spk0 = 4'b0011;
        for (int k = 0; k <= 100; k++) cyc();
        @(negedge clk);
        chk_u0("drop101", 1'b1, 4'd8, 4'b0011, 16'd192);
        for (int k = 0; k < 40000; k++) cyc();
        @(negedge clk);
        chk("sat.dropped", 32'(drp0), 32'hFFFF);
        for (int k = 0; k < 5; k++) cyc();
        @(negedge clk);
        chk("sat_hold.dropped", 32'(drp0), 32'hFFFF);
        chk("sat_hold.pending", 32'(pnd0), 32'b0011);

        // Reset clears counters; then reset mid-stream at level 5
        rst0 = 1'b1; spk0 = '0;
        cyc();
        rst0 = 1'b0;
        @(negedge clk);
        chk_u0("post_sat_rst", 1'b0, 4'd0, 4'b0000, 16'd0);
        spk0 = 4'b1111; cyc();
        spk0 = 4'b0000; cyc();
        spk0 = 4'b0001; cyc();
        spk0 = 4'b0000; cyc(); cyc(); cyc();
        @(negedge clk);
        chk_u0("lvl5", 1'b1, 4'd5, 4'b0000, 16'd0);
        rst0 = 1'b1; spk0 = 4'b0000;
        cyc();
        rst0 = 1'b0;
        @(negedge clk);
        chk_u0("mid_rst", 1'b0, 4'd0, 4'b0000, 16'd0);
        spk0 = 4'b0100; cyc();
        spk0 = 4'b0000; cyc();
        @(negedge clk);
        chk("rst_ts.valid", 32'(vld0), 32'd1);
        chk("rst_ts.col", 32'(col0), 32'd2);
        chk("rst_ts.time", 32'(tim0), 32'd0);

        // Single column, 4-bit timestamp wrap with back-to-back spikes
        rst1 = 1'b1; rdy1 = 1'b1; spk1 = '0;
        cyc();
        rst1 = 1'b0;
        for (int k = 0; k < 15; k++) cyc();
        spk1 = 1'b1; cyc();
        spk1 = 1'b1; cyc();
        spk1 = 1'b0;
        @(negedge clk);
        chk("wrap0.valid", 32'(vld1), 32'd1);
        chk("wrap0.col", 32'(col1), 32'd0);
        chk("wrap0.time", 32'(tim1), 32'd15);
        chk("wrap0.pending", 32'(pnd1), 32'd1);
        chk("wrap0.dropped", 32'(drp1), 32'd0);
        cyc();
        @(negedge clk);
        chk("wrap1.valid", 32'(vld1), 32'd1);
        chk("wrap1.col", 32'(col1), 32'd0);
        chk("wrap1.time", 32'(tim1), 32'd0);
        chk("wrap1.level", 32'(lvl1), 32'd1);
        chk("wrap1.dropped", 32'(drp1), 32'd0);
        cyc();
        @(negedge clk);
        chk("wrap2.valid", 32'(vld1), 32'd0);
        chk("wrap2.level", 32'(lvl1), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
